// File: rtl/line_fill_memory.sv
// line_fill_memory: word memory shared by an instruction and a data requester.
// Reads return a 4-word line as a beat burst; writes commit a single word.
// Optional feature macro: CRITICAL_WORD_FIRST_EN (burst starts at the
// requested word and wraps within the line).
module line_fill_memory #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    // instruction port: line reads only
    input  logic                 ic_req,
    input  logic [WORD_SIZE-1:0] ic_addr,
    output logic                 ic_gnt,
    output logic [WORD_SIZE-1:0] ic_rdata,
    output logic                 ic_rvalid,
    output logic [1:0]           ic_rbeat,
    output logic                 ic_rlast,
    // data port: line reads and word writes
    input  logic                 dc_req,
    input  logic                 dc_we,
    input  logic [WORD_SIZE-1:0] dc_addr,
    input  logic [WORD_SIZE-1:0] dc_wdata,
    output logic                 dc_gnt,
    output logic [WORD_SIZE-1:0] dc_rdata,
    output logic                 dc_rvalid,
    output logic [1:0]           dc_rbeat,
    output logic                 dc_rlast,
    output logic                 dc_wack,
    output logic                 busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        WACK
    } state_t;

    // storage, deliberately outside the reset domain
    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    // control state
    state_t               state_q;
    logic [3:0]           cnt_q;
    logic [2:0]           beat_q;

    // request captured at accept
    logic                 port_dc_q;
    logic                 we_q;
    logic [AW-1:0]        addr_q;
    logic [WORD_SIZE-1:0] wdata_q;

    // registered response, steered to the granted port
    logic                 gnt_q;
    logic                 rvalid_q;
    logic                 rlast_q;
    logic [1:0]           rbeat_q;
    logic [WORD_SIZE-1:0] rdata_q;
    logic                 wack_q;

    // next-beat helpers
    logic                 fire_d;
    logic                 emit_d;
    logic                 commit_d;
    logic [1:0]           start_d;
    logic [1:0]           offset_d;
    logic [AW-1:0]        rd_index_d;
    logic [AW-1:0]        acc_addr_d;

    // upper address bits alias onto the same words and are never decoded
    if (AW < WORD_SIZE) begin : g_alias
        logic unused_upper;
        assign unused_upper = ^{ic_addr[WORD_SIZE-1:AW],
                                dc_addr[WORD_SIZE-1:AW]};
    end

    // beat order, read index and the countdown expiry for this cycle
    always_comb begin
        fire_d     = 1'b0;
        emit_d     = 1'b0;
        commit_d   = 1'b0;
        start_d    = 2'b00;
        offset_d   = 2'b00;
        rd_index_d = '0;
        acc_addr_d = '0;

`ifdef CRITICAL_WORD_FIRST_EN
        start_d = addr_q[1:0];
`else
        start_d = 2'b00;
`endif

        offset_d   = start_d + beat_q[1:0];
        rd_index_d = {addr_q[AW-1:2], offset_d};

        fire_d = (state_q == WAIT) && (cnt_q == 4'd1);

        emit_d = (fire_d && !we_q) ||
                 ((state_q == BURST) && (beat_q != 3'd4));

        // a reset edge must not let a pending write land
        commit_d = reset_n && fire_d && we_q;

        // data port wins when both request on the same edge
        acc_addr_d = dc_req ? dc_addr[AW-1:0] : ic_addr[AW-1:0];
    end

    // word write at the end of the access latency
    always_ff @(posedge clk) begin
        if (commit_d) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    // request sequencer: accept, wait out latency, burst or write ack
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            beat_q    <= 3'd0;
            port_dc_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            gnt_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rbeat_q   <= 2'b00;
            rdata_q   <= '0;
            wack_q    <= 1'b0;
        end else begin
            // response strobes are single-cycle unless set below
            gnt_q    <= 1'b0;
            wack_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rbeat_q  <= 2'b00;
            rdata_q  <= '0;

            if (emit_d) begin
                rvalid_q <= 1'b1;
                rbeat_q  <= offset_d;
                rdata_q  <= mem_q[rd_index_d];
                rlast_q  <= (beat_q == 3'd3);
            end

            unique case (state_q)
                IDLE: begin
                    if (dc_req || ic_req) begin
                        port_dc_q <= dc_req;
                        we_q      <= dc_req && dc_we;
                        addr_q    <= acc_addr_d;
                        wdata_q   <= dc_wdata;
                        gnt_q     <= 1'b1;
                        cnt_q     <= 4'(LATENCY);
                        beat_q    <= 3'd0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (fire_d) begin
                        cnt_q <= 4'd0;
                        if (we_q) begin
                            wack_q  <= 1'b1;
                            state_q <= WACK;
                        end else begin
                            beat_q  <= 3'd1;
                            state_q <= BURST;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                BURST: begin
                    if (beat_q == 3'd4) begin
                        beat_q  <= 3'd0;
                        state_q <= IDLE;
                    end else begin
                        beat_q <= beat_q + 3'd1;
                    end
                end
                WACK: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // port steering: the idle port sees all zeros
    always_comb begin
        ic_gnt    = gnt_q && !port_dc_q;
        ic_rvalid = rvalid_q && !port_dc_q;
        ic_rlast  = rlast_q && !port_dc_q;
        ic_rbeat  = port_dc_q ? 2'b00 : rbeat_q;
        ic_rdata  = port_dc_q ? '0 : rdata_q;

        dc_gnt    = gnt_q && port_dc_q;
        dc_rvalid = rvalid_q && port_dc_q;
        dc_rlast  = rlast_q && port_dc_q;
        dc_rbeat  = port_dc_q ? rbeat_q : 2'b00;
        dc_rdata  = port_dc_q ? rdata_q : '0;
        dc_wack   = wack_q;

        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_line_fill_memory.sv
// Bench for line_fill_memory: scoreboard of expected grants, beats and
// write acks against a flat array model, plus a LATENCY=1 instance.
module tb_line_fill_memory;

    localparam int W = 16;
    localparam int D = 256;
    localparam int L = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          ic_req, ic_gnt, ic_rvalid, ic_rlast;
    logic [W-1:0]  ic_addr, ic_rdata;
    logic [1:0]    ic_rbeat;
    logic          dc_req, dc_we, dc_gnt, dc_rvalid, dc_rlast, dc_wack;
    logic [W-1:0]  dc_addr, dc_wdata, dc_rdata;
    logic [1:0]    dc_rbeat;
    logic          busy;

    logic          j_ic_req, j_ic_gnt, j_ic_rvalid, j_ic_rlast;
    logic [W-1:0]  j_ic_addr, j_ic_rdata;
    logic [1:0]    j_ic_rbeat;
    logic          j_dc_req, j_dc_we, j_dc_gnt, j_dc_rvalid, j_dc_rlast;
    logic          j_dc_wack;
    logic [W-1:0]  j_dc_addr, j_dc_wdata, j_dc_rdata;
    logic [1:0]    j_dc_rbeat;
    logic          j_busy;

    line_fill_memory #(.WORD_SIZE(W), .DEPTH(D), .LATENCY(L)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
        .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_rbeat(ic_rbeat),
        .ic_rlast(ic_rlast),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_gnt(dc_gnt), .dc_rdata(dc_rdata),
        .dc_rvalid(dc_rvalid), .dc_rbeat(dc_rbeat), .dc_rlast(dc_rlast),
        .dc_wack(dc_wack), .busy(busy)
    );

    line_fill_memory #(.WORD_SIZE(W), .DEPTH(D), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .ic_req(j_ic_req), .ic_addr(j_ic_addr), .ic_gnt(j_ic_gnt),
        .ic_rdata(j_ic_rdata), .ic_rvalid(j_ic_rvalid),
        .ic_rbeat(j_ic_rbeat), .ic_rlast(j_ic_rlast),
        .dc_req(j_dc_req), .dc_we(j_dc_we), .dc_addr(j_dc_addr),
        .dc_wdata(j_dc_wdata), .dc_gnt(j_dc_gnt), .dc_rdata(j_dc_rdata),
        .dc_rvalid(j_dc_rvalid), .dc_rbeat(j_dc_rbeat),
        .dc_rlast(j_dc_rlast), .dc_wack(j_dc_wack), .busy(j_busy)
    );

    // kind: 0 grant, 1 read beat, 2 write ack
    typedef struct {
        int          kind;
        bit          dc;
        int          t;
        logic [1:0]  beat;
        logic [15:0] data;
        bit          last;
    } ev_t;

    ev_t         exp_q[$];
    int          bfrom_q[$];
    int          bto_q[$];
    logic [15:0] model [D];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int free_edge = 0;
    bit mon_en = 1'b0;

    // edge number: value seen at the following falling edge
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // word offset delivered as the k-th beat of a line read
    function automatic int order_off(input logic [15:0] a, input int k);
`ifdef CRITICAL_WORD_FIRST_EN
        return (int'(a[1:0]) + k) % 4;
`else
        return k + 0 * int'(a[0]);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h at cyc=%0d",
                     name, act, req, cyc);
        end
    endtask

    // expected events of one accepted request; keep trims aborted ones
    task automatic plan(input bit dc, input bit we, input logic [15:0] a,
                        input logic [15:0] wd, input int e0,
                        input int keep);
        ev_t e;
        int  off;
        logic [7:0] idx;
        e.kind = 0; e.dc = dc; e.t = e0;
        e.beat = 2'd0; e.data = 16'h0; e.last = 1'b0;
        exp_q.push_back(e);
        if (we) begin
            if (keep > 0) begin
                model[a[7:0]] = wd;
                e.kind = 2; e.t = e0 + L;
                exp_q.push_back(e);
            end
        end else begin
            for (int k = 0; k < keep; k++) begin
                off = order_off(a, k);
                idx = {a[7:2], 2'(off)};
                e.kind = 1;
                e.t = e0 + L + k;
                e.beat = 2'(off);
                e.data = model[idx];
                e.last = (k == 3);
                exp_q.push_back(e);
            end
        end
    endtask

    // one or two requests raised together; dropped once accepted
    task automatic issue(input bit do_dc, input bit dwe,
                         input logic [15:0] daddr, input logic [15:0] dwd,
                         input bit do_ic, input logic [15:0] iaddr);
        int e_dc;
        int e_ic;
        e_dc = 0;
        e_ic = 0;
        @(negedge clk);
        if (do_dc) begin
            dc_req = 1'b1; dc_we = dwe; dc_addr = daddr; dc_wdata = dwd;
            e_dc = imax(cyc + 1, free_edge);
            plan(1'b1, dwe, daddr, dwd, e_dc, dwe ? 1 : 4);
            bfrom_q.push_back(e_dc);
            bto_q.push_back(e_dc + L + (dwe ? 0 : 3));
            free_edge = e_dc + L + (dwe ? 2 : 5);
        end
        if (do_ic) begin
            ic_req = 1'b1; ic_addr = iaddr;
            e_ic = imax(cyc + 1, free_edge);
            plan(1'b0, 1'b0, iaddr, 16'h0, e_ic, 4);
            bfrom_q.push_back(e_ic);
            bto_q.push_back(e_ic + L + 3);
            free_edge = e_ic + L + 5;
        end
        while (dc_req || ic_req) begin
            if (dc_req && cyc >= e_dc) begin
                dc_req = 1'b0; dc_we = 1'($urandom);
                dc_addr = 16'($urandom); dc_wdata = 16'($urandom);
            end
            if (ic_req && cyc >= e_ic) begin
                ic_req = 1'b0; ic_addr = 16'($urandom);
            end
            if (dc_req || ic_req) @(negedge clk);
        end
    endtask

    // request cut short by reset at edge e0+roff
    task automatic issue_abort(input bit dc, input bit we,
                               input logic [15:0] a, input logic [15:0] wd,
                               input int keep, input int roff);
        int e0;
        @(negedge clk);
        e0 = imax(cyc + 1, free_edge);
        if (dc) begin
            dc_req = 1'b1; dc_we = we; dc_addr = a; dc_wdata = wd;
        end else begin
            ic_req = 1'b1; ic_addr = a;
        end
        plan(dc, we, a, wd, e0, keep);
        bfrom_q.push_back(e0);
        bto_q.push_back(e0 + roff - 1);
        while (cyc < e0) @(negedge clk);
        dc_req = 1'b0;
        ic_req = 1'b0;
        while (cyc < e0 + roff - 1) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        free_edge = cyc + 1;
    endtask

    task automatic see(input int kind, input bit dc, input logic [1:0] beat,
                       input logic [15:0] data, input bit last);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d dc=%0d cyc=%0d required none",
                     kind, dc, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.dc != dc || e.t != cyc ||
                e.beat != beat || e.data != data || e.last != last) begin
                failures++;
                $display("FAIL event got kind=%0d dc=%0d t=%0d beat=%0d data=%h last=%0d required kind=%0d dc=%0d t=%0d beat=%0d data=%h last=%0d",
                         kind, dc, cyc, beat, data, last,
                         e.kind, e.dc, e.t, e.beat, e.data, e.last);
            end
        end
    endtask

    // monitor: pop and compare whenever the DUT presents something
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_event kind=%0d dc=%0d due=%0d now=%0d",
                         exp_q[0].kind, exp_q[0].dc, exp_q[0].t, cyc);
                exp_q.delete(0);
            end
            if (dc_gnt) see(0, 1'b1, 2'd0, 16'h0, 1'b0);
            if (ic_gnt) see(0, 1'b0, 2'd0, 16'h0, 1'b0);
            if (dc_rvalid) see(1, 1'b1, dc_rbeat, dc_rdata, dc_rlast);
            if (ic_rvalid) see(1, 1'b0, ic_rbeat, ic_rdata, ic_rlast);
            if (dc_wack) see(2, 1'b1, 2'd0, 16'h0, 1'b0);
            while (bto_q.size() > 0 && bto_q[0] < cyc) begin
                bfrom_q.delete(0);
                bto_q.delete(0);
            end
            chk("busy", 32'(busy),
                32'(bfrom_q.size() > 0 && bfrom_q[0] <= cyc));
            chk("quiet_outputs",
                32'((!ic_rvalid && (ic_rdata != 0 || ic_rbeat != 0 || ic_rlast)) ||
                    (!dc_rvalid && (dc_rdata != 0 || dc_rbeat != 0 || dc_rlast))),
                32'd0);
        end
    end

    int r;
    int jo;
    logic [15:0] ra;

    initial begin
        reset_n = 1'b0;
        ic_req = 1'b0; ic_addr = 16'h0;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 16'h0; dc_wdata = 16'hFFFF;
        j_ic_req = 1'b0; j_ic_addr = 16'h0;
        j_dc_req = 1'b0; j_dc_we = 1'b0; j_dc_addr = 16'h0;
        j_dc_wdata = 16'h0;

        // requests during reset must be ignored
        repeat (3) @(negedge clk);
        chk("rst_dc_gnt", 32'(dc_gnt), 32'd0);
        chk("rst_ic_gnt", 32'(ic_gnt), 32'd0);
        chk("rst_rvalid", 32'({ic_rvalid, dc_rvalid}), 32'd0);
        chk("rst_rdata", {ic_rdata, dc_rdata}, 32'd0);
        chk("rst_rbeat_rlast", 32'({ic_rbeat, dc_rbeat, ic_rlast, dc_rlast}), 32'd0);
        chk("rst_wack", 32'(dc_wack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        dc_req = 1'b0;
        reset_n = 1'b1;
        free_edge = cyc + 1;
        mon_en = 1'b1;

        // fill every word, with random upper address bits
        for (int i = 0; i < D; i++) begin
            ra = {8'($urandom), 8'(i)};
            issue(1'b1, 1'b1, ra, 16'($urandom), 1'b0, 16'h0);
        end

        // line 0x10 preload, critical read at 0x12, then aliased 0x113
        for (int k = 0; k < 4; k++)
            issue(1'b1, 1'b1, 16'(16'h0010 + k), 16'(16'h00A0 + k),
                  1'b0, 16'h0);
        issue(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0012);
        issue(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0113);

        // simultaneous requests: data port first
        issue(1'b1, 1'b0, 16'h0020, 16'h0, 1'b1, 16'h0012);

        // write then read back through the line
        issue(1'b1, 1'b1, 16'h0005, 16'hBEEF, 1'b0, 16'h0);
        issue(1'b1, 1'b0, 16'h0004, 16'h0, 1'b0, 16'h0);

        // reset on beat 2, then reset during a write's wait
        issue_abort(1'b0, 1'b0, 16'h0010, 16'h0, 2, L + 2);
        issue(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0);
        issue_abort(1'b1, 1'b1, 16'h0005, 16'h1234, 0, 1);
        issue(1'b1, 1'b0, 16'h0006, 16'h0, 1'b0, 16'h0);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            ra = 16'($urandom);
            if (r < 3)
                issue(1'b1, 1'b1, ra, 16'($urandom), 1'b0, 16'h0);
            else if (r < 6)
                issue(1'b1, 1'b0, ra, 16'h0, 1'b0, 16'h0);
            else if (r < 9)
                issue(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, ra);
            else
                issue(1'b1, 1'($urandom_range(0, 1)), ra, 16'($urandom),
                      1'b1, 16'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        while (cyc < free_edge + 2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        // LATENCY=1 instance: writes ack one edge after accept
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            j_dc_req = 1'b1; j_dc_we = 1'b1;
            j_dc_addr = 16'(16'h0130 + k);
            j_dc_wdata = 16'(16'h5A00 + k);
            @(negedge clk);
            chk("l1_dc_gnt", 32'(j_dc_gnt), 32'd1);
            j_dc_req = 1'b0;
            @(negedge clk);
            chk("l1_wack", 32'({j_dc_wack, j_dc_rvalid}), 32'b10);
            @(negedge clk);
            chk("l1_idle", 32'(j_busy), 32'd0);
        end
        @(negedge clk);
        j_ic_req = 1'b1; j_ic_addr = 16'h0032;
        @(negedge clk);
        chk("l1_ic_gnt", 32'(j_ic_gnt), 32'd1);
        j_ic_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            jo = order_off(16'h0032, k);
            chk("l1_rvalid", 32'(j_ic_rvalid), 32'd1);
            chk("l1_rbeat", 32'(j_ic_rbeat), 32'(jo));
            chk("l1_rdata", 32'(j_ic_rdata), 32'(16'h5A00 + jo));
            chk("l1_rlast", 32'(j_ic_rlast), 32'(k == 3));
        end
        @(negedge clk);
        chk("l1_burst_end", 32'(j_ic_rvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
